sram22_rw_adapter: RTL and testbench

Request/response front end for an sram22 single-port macro (clk, we, wmask, addr, din, dout; registered read, one-cycle read latency, dout undefined after a write). It accepts read/write requests on a valid/ready channel, drives the macro's pins, and captures each read's dout into a small response FIFO. Read data is presented on a valid/ready response channel with full throughput and backpressure. It sits between a bus client and the macro.

---
 rtl/sram22_rw_adapter.sv | 123 ++++++++++++
 tb/tb_sram22_rw_adapter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram22_rw_adapter.sv
// Valid/ready request/response front end for an sram22 single-port macro.
// Reads are credit-checked against a small response FIFO so captures never overflow.
module sram22_rw_adapter #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 6,
  parameter int unsigned WMASK_WIDTH = 8,
  parameter int unsigned RSP_DEPTH   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [WMASK_WIDTH-1:0] req_wmask,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0]  req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_WIDTH-1:0]  rsp_rdata,
  output logic                   sram_we,
  output logic [WMASK_WIDTH-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]  sram_din,
  input  logic [DATA_WIDTH-1:0]  sram_dout
);

  localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int unsigned SPC_W = CNT_W + 1;

  if ((DATA_WIDTH % WMASK_WIDTH) != 0) begin : g_bad_mask
    $error("DATA_WIDTH must be a multiple of WMASK_WIDTH");
  end
  if (RSP_DEPTH < 2) begin : g_bad_depth
    $error("RSP_DEPTH must be at least 2");
  end

  logic                  rd_pend_q, rd_pend_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] buf_q [RSP_DEPTH];
  logic [DATA_WIDTH-1:0] buf_d [RSP_DEPTH];

  logic             fire;
  logic             rd_fire;
  logic             push;
  logic             pop;
  logic [SPC_W-1:0] space;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshakes and credit: outstanding reads (in flight plus buffered) never exceed depth
  always_comb begin
    rsp_valid = !rst && (cnt_q != '0);
    rsp_rdata = buf_q[rd_ptr_q];
    pop       = rsp_valid && rsp_ready;
    push      = rd_pend_q;
    space     = SPC_W'(RSP_DEPTH) - SPC_W'(cnt_q) - SPC_W'(rd_pend_q) + SPC_W'(pop);
    req_ready = !rst && (req_we || (space != '0));
    fire      = req_valid && req_ready;
    rd_fire   = fire && !req_we;
  end

  // Macro pins follow the request only on fire; idle cycles read address 0
  always_comb begin
    sram_we    = 1'b0;
    sram_wmask = '0;
    sram_addr  = '0;
    sram_din   = '0;
    if (fire) begin
      sram_we    = req_we;
      sram_wmask = req_wmask;
      sram_addr  = req_addr;
      sram_din   = req_wdata;
    end
  end

  // Next-state for the read tracker and response FIFO
  always_comb begin
    rd_pend_d = rd_fire;
    cnt_d     = cnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    buf_d     = buf_q;
    if (push) begin
      buf_d[wr_ptr_q] = sram_dout;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend_q <= 1'b0;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      rd_pend_q <= rd_pend_d;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  // Payload storage needs no reset; validity is tracked by cnt_q
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && !pop && (cnt_q == CNT_W'(RSP_DEPTH))));
    end
  end

endmodule

// File: tb/tb_sram22_rw_adapter.sv
// Bench for sram22_rw_adapter: behavioural sram macro, transaction-level model and directed tests.
module tb_sram22_rw_adapter;

  localparam int DW    = 32;
  localparam int AW    = 6;
  localparam int MW    = 8;
  localparam int DEPTH = 2;
  localparam int LANE  = DW / MW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [MW-1:0] req_wmask = '0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          sram_we;
  logic [MW-1:0] sram_wmask;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic [DW-1:0] sram_dout = '0;

  sram22_rw_adapter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW), .RSP_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_wmask(req_wmask), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .sram_we(sram_we), .sram_wmask(sram_wmask), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Macro: registered read, dout scrambled after a write
  logic [DW-1:0] macro_mem [64];
  always @(posedge clk) begin
    if (sram_we) begin
      for (int k = 0; k < MW; k++)
        if (sram_wmask[k]) macro_mem[sram_addr][k*LANE +: LANE] = sram_din[k*LANE +: LANE];
      sram_dout <= $urandom;
    end else begin
      sram_dout <= macro_mem[sram_addr];
    end
  end

  // Transaction model: golden memory plus queue of accepted reads with their due cycle
  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic [DW-1:0] gold [64];
  exp_t          q [$];
  int            cyc = 0;
  logic [DW-1:0] got_d [$];
  int            got_c [$];
  int            rd_fires = 0;
  int            last_rd_cyc = -1;

  initial begin
    for (int i = 0; i < 64; i++) begin
      macro_mem[i] = 32'hA5A5_0000 | DW'(i);
      gold[i]      = 32'hA5A5_0000 | DW'(i);
    end
  end

  always @(negedge clk) begin
    bit ev, pop, er, fire;
    ev   = !rst && (q.size() > 0) && (q[0].due <= cyc);
    pop  = ev && rsp_ready;
    er   = !rst && (req_we || ((q.size() - int'(pop)) < DEPTH));
    fire = req_valid && er;
    chk("req_ready", DW'(req_ready), DW'(er));
    chk("rsp_valid", DW'(rsp_valid), DW'(ev));
    if (ev) chk("rsp_rdata", rsp_rdata, q[0].data);
    chk("sram_we", DW'(sram_we), DW'(fire && req_we));
    chk("sram_wmask", DW'(sram_wmask), fire ? DW'(req_wmask) : '0);
    chk("sram_addr", DW'(sram_addr), fire ? DW'(req_addr) : '0);
    chk("sram_din", sram_din, fire ? req_wdata : '0);
    if (rsp_valid && rsp_ready) begin
      got_d.push_back(rsp_rdata);
      got_c.push_back(cyc);
    end
    if (req_valid && req_ready && !req_we) begin
      rd_fires++;
      last_rd_cyc = cyc;
    end
    if (rst) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (fire) begin
        if (req_we) begin
          for (int k = 0; k < MW; k++)
            if (req_wmask[k]) gold[req_addr][k*LANE +: LANE] = req_wdata[k*LANE +: LANE];
        end else begin
          q.push_back('{gold[req_addr], cyc + 2});
        end
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic send(input bit we, input logic [MW-1:0] m, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, output int stalls);
    int n;
    n = 0;
    req_valid = 1'b1; req_we = we; req_wmask = m; req_addr = a; req_wdata = d;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_accepted", DW'(n < 50), 32'd1);
    stalls = n;
    step();
    req_valid = 1'b0; req_we = 1'b0; req_wmask = '0; req_addr = '0; req_wdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, acc, gb, base, fire_seen, t0;

    // Reset held with a write offered: nothing may fire
    rst = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_wmask = 8'hFF; req_addr = 6'd3; req_wdata = 32'h1234_5678;
    repeat (3) begin
      @(negedge clk);
      chk("rst_req_ready", DW'(req_ready), 32'd0);
      chk("rst_sram_we", DW'(sram_we), 32'd0);
      step();
    end
    rst = 1'b0;
    idle(2);
    rsp_ready = 1'b1;

    // Single read right after a full write
    gb = got_d.size();
    send(1'b1, 8'hFF, 6'd5, 32'hDEAD_BEEF, st);
    send(1'b0, 8'h00, 6'd5, 32'h0, st);
    t0 = last_rd_cyc;
    idle(4);
    chk("single_count", DW'(got_d.size() - gb), 32'd1);
    if (got_d.size() > gb) begin
      chk("single_data", got_d[gb], 32'hDEAD_BEEF);
      chk("single_latency", DW'(got_c[gb] - t0), 32'd2);
    end

    // Address 3 survived the reset-time write
    gb = got_d.size();
    send(1'b0, 8'h00, 6'd3, 32'h0, st);
    idle(4);
    chk("rst_mem_kept", (got_d.size() > gb) ? got_d[gb] : 32'hX, 32'hA5A5_0003);

    // Streaming
    for (int i = 0; i < 16; i++) send(1'b1, 8'hFF, AW'(i), DW'(i) * 32'h0101_0101, st);
    gb = got_d.size();
    acc = 0;
    for (int i = 0; i < 16; i++) begin
      send(1'b0, 8'h00, AW'(i), 32'h0, st);
      acc += st;
    end
    idle(4);
    chk("stream_stalls", DW'(acc), 32'd0);
    chk("stream_count", DW'(got_d.size() - gb), 32'd16);
    if (got_d.size() >= gb + 16) begin
      for (int i = 0; i < 16; i++) begin
        chk("stream_data", got_d[gb+i], DW'(i) * 32'h0101_0101);
        chk("stream_gap", DW'(got_c[gb+i] - got_c[gb]), DW'(i));
      end
    end

    // Backpressure: two reads fire then reads stall; a write still goes through
    rsp_ready = 1'b0;
    gb = got_d.size();
    base = rd_fires;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 6'd1;
    repeat (6) begin
      @(negedge clk);
      fire_seen = int'(req_ready);
      step();
      if (fire_seen != 0) req_addr = req_addr + 6'd1;
    end
    chk("bp_fires", DW'(rd_fires - base), 32'd2);
    chk("bp_next_addr", DW'(req_addr), 32'd3);
    req_we = 1'b1; req_addr = 6'd20; req_wmask = 8'hFF; req_wdata = 32'h1414_1414;
    @(negedge clk);
    chk("bp_write_ready", DW'(req_ready), 32'd1);
    step();
    req_we = 1'b0; req_addr = 6'd3; req_wmask = '0; req_wdata = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_read_resume", DW'(req_ready), 32'd1);
    step();
    idle(5);
    chk("bp_count", DW'(got_d.size() - gb), 32'd3);
    if (got_d.size() >= gb + 3) begin
      chk("bp_order0", got_d[gb],   32'h0101_0101);
      chk("bp_order1", got_d[gb+1], 32'h0202_0202);
      chk("bp_order2", got_d[gb+2], 32'h0303_0303);
    end

    // Masked write and immediate read-back
    gb = got_d.size();
    send(1'b1, 8'hFF, 6'd9, 32'hFFFF_FFFF, st);
    send(1'b1, 8'h0F, 6'd9, 32'h0000_0000, st);
    send(1'b0, 8'h00, 6'd9, 32'h0, st);
    idle(4);
    chk("mask_data", (got_d.size() > gb) ? got_d[gb] : 32'hX, 32'hFFFF_0000);

    // Reset with two reads outstanding discards both
    rsp_ready = 1'b0;
    send(1'b0, 8'h00, 6'd4, 32'h0, st);
    send(1'b0, 8'h00, 6'd5, 32'h0, st);
    rst = 1'b1;
    step();
    rst = 1'b0;
    gb = got_d.size();
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("midrst_valid", DW'(rsp_valid), 32'd0);
    step();
    idle(4);
    chk("midrst_stale", DW'(got_d.size() - gb), 32'd0);
    send(1'b0, 8'h00, 6'd6, 32'h0, st);
    t0 = last_rd_cyc;
    idle(4);
    chk("midrst_new_count", DW'(got_d.size() - gb), 32'd1);
    if (got_d.size() > gb) begin
      chk("midrst_new_data", got_d[gb], 32'h0606_0606);
      chk("midrst_new_lat", DW'(got_c[gb] - t0), 32'd2);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
